// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a five-stage in-order pipeline: load-use stall, taken-branch flush, data-memory wait freeze.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating Stall_Count / Flush_Count outputs.
module pipeline_hazard_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IF_ID_Rs1,
    input  logic [4:0]  IF_ID_Rs2,
    input  logic [4:0]  ID_EX_Rd,
    input  logic        ID_EX_MemRead,
    input  logic        Branch_Taken,
    input  logic        Mem_Busy,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        Pipe_Freeze,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0] Stall_Count,
    output logic [15:0] Flush_Count,
`endif
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FLUSH    = 2'b10,
        MEM_WAIT = 2'b11
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_load_use;

    // rd==x0 never carries a real dependency, so it must not stall.
    assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                        ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        w_next_state = RUN;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;

        // Reset forces defaults combinationally, so outputs recover without waiting for clk.
        if (!reset) begin
            case (r_state)
                MEM_WAIT: begin
                    // Execute is frozen; branch and load-use get re-raised once it moves.
                    if (Mem_Busy) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        Pipe_Freeze  = 1'b1;
                        w_next_state = MEM_WAIT;
                    end
                end
                default: begin
                    if (Mem_Busy) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        Pipe_Freeze  = 1'b1;
                        w_next_state = MEM_WAIT;
                    end else if (Branch_Taken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Flush  = 1'b1;
                        w_next_state = FLUSH;
                    end else if (w_load_use) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Flush  = 1'b1;
                        w_next_state = LU_STALL;
                    end
                end
            endcase
        end
    end

    assign State = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            if (!PC_Write && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (IF_ID_Flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign Stall_Count = r_stall_count;
    assign Flush_Count = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus randomized traffic vs. a rule-level model.
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        reset;
    logic [4:0]  IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
    logic        ID_EX_MemRead, Branch_Taken, Mem_Busy;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze;
    logic [1:0]  State;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] Stall_Count, Flush_Count;
`endif

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller dut (
        .clk           (clk),
        .reset         (reset),
        .IF_ID_Rs1     (IF_ID_Rs1),
        .IF_ID_Rs2     (IF_ID_Rs2),
        .ID_EX_Rd      (ID_EX_Rd),
        .ID_EX_MemRead (ID_EX_MemRead),
        .Branch_Taken  (Branch_Taken),
        .Mem_Busy      (Mem_Busy),
        .PC_Write      (PC_Write),
        .IF_ID_Write   (IF_ID_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Flush   (ID_EX_Flush),
        .Pipe_Freeze   (Pipe_Freeze),
`ifdef HAZARD_PERF_CNT_EN
        .Stall_Count   (Stall_Count),
        .Flush_Count   (Flush_Count),
`endif
        .State         (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze}
    localparam logic [4:0] O_DEF    = 5'b11000;
    localparam logic [4:0] O_STALL  = 5'b00010;
    localparam logic [4:0] O_FLUSH  = 5'b11110;
    localparam logic [4:0] O_FREEZE = 5'b00001;

    function automatic logic [4:0] outs();
        return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic mr, input logic bt, input logic mb);
        IF_ID_Rs1     = rs1;
        IF_ID_Rs2     = rs2;
        ID_EX_Rd      = rd;
        ID_EX_MemRead = mr;
        Branch_Taken  = bt;
        Mem_Busy      = mb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        #1;
        checks++;
        if (State !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", State); end
        checks++;
        if (outs() !== O_DEF) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), O_DEF); end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        #1;
        checks++;
        if (State !== 2'b00 || outs() !== O_DEF) begin
            errors++; $display("FAIL idle_after_reset state %b outs %b exp 00 %b", State, outs(), O_DEF);
        end
    endtask

    task automatic test_load_use();
        set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs() !== O_STALL) begin errors++; $display("FAIL lu_outs got %b exp %b", outs(), O_STALL); end
        tick();
        set_in(5'd1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (State !== 2'b01 || outs() !== O_DEF) begin
            errors++; $display("FAIL lu_next state %b outs %b exp 01 %b", State, outs(), O_DEF);
        end
        // Back-to-back load-use while in LU_STALL stalls again.
        set_in(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs() !== O_STALL) begin errors++; $display("FAIL lu_b2b_outs got %b exp %b", outs(), O_STALL); end
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (State !== 2'b01) begin errors++; $display("FAIL lu_b2b_state got %b exp 01", State); end
        tick();
        checks++;
        if (State !== 2'b00) begin errors++; $display("FAIL lu_return got %b exp 00", State); end
    endtask

    task automatic test_rd_zero();
        set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs() !== O_DEF) begin errors++; $display("FAIL rd0_outs got %b exp %b", outs(), O_DEF); end
        tick();
        checks++;
        if (State !== 2'b00) begin errors++; $display("FAIL rd0_state got %b exp 00", State); end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_priority();
        set_in(5'd3, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (outs() !== O_FLUSH) begin errors++; $display("FAIL prio_outs got %b exp %b", outs(), O_FLUSH); end
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (State !== 2'b10 || outs() !== O_DEF) begin
            errors++; $display("FAIL prio_next state %b outs %b exp 10 %b", State, outs(), O_DEF);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        set_in(5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs() !== O_FREEZE) begin errors++; $display("FAIL mw_freeze[%0d] got %b exp %b", i, outs(), O_FREEZE); end
            checks++;
            if (State !== ((i == 0) ? 2'b00 : 2'b11)) begin
                errors++; $display("FAIL mw_state[%0d] got %b", i, State);
            end
            tick();
        end
        Mem_Busy = 1'b0;
        #1;
        checks++;
        if (State !== 2'b11 || outs() !== O_DEF) begin
            errors++; $display("FAIL mw_release state %b outs %b exp 11 %b", State, outs(), O_DEF);
        end
        tick();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (State !== 2'b00) begin errors++; $display("FAIL mw_return got %b exp 00", State); end
    endtask

    task automatic test_reset_async();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checks++;
        if (State !== 2'b11 || PC_Write !== 1'b0) begin
            errors++; $display("FAIL ra_setup state %b pcw %b exp 11 0", State, PC_Write);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (State !== 2'b00 || PC_Write !== 1'b1 || outs() !== O_DEF) begin
            errors++; $display("FAIL ra_async state %b outs %b exp 00 %b", State, outs(), O_DEF);
        end
        tick();
        // Load-use present at release: first edge must evaluate from RUN.
        set_in(5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== O_STALL) begin errors++; $display("FAIL ra_release_outs got %b exp %b", outs(), O_STALL); end
        tick();
        checks++;
        if (State !== 2'b01) begin errors++; $display("FAIL ra_release_state got %b exp 01", State); end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // Reference model: tracks only "frozen on memory" and "what the last cycle reacted to".
    task automatic test_random();
        bit       m_frozen = 1'b0;
        logic [1:0] m_state = 2'b00;
        logic [4:0] m_out;
        bit       lu;
        int       bad = 0;
        for (int n = 0; n < 3000; n++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
            lu = ID_EX_MemRead && ID_EX_Rd != 0 && (ID_EX_Rd == IF_ID_Rs1 || ID_EX_Rd == IF_ID_Rs2);
            if (Mem_Busy)          m_out = O_FREEZE;
            else if (m_frozen)     m_out = O_DEF;
            else if (Branch_Taken) m_out = O_FLUSH;
            else if (lu)           m_out = O_STALL;
            else                   m_out = O_DEF;
            #1;
            checks++;
            if (outs() !== m_out || State !== m_state) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand[%0d] outs %b state %b exp %b %b", n, outs(), State, m_out, m_state);
            end
            checks++;
            if (IF_ID_Flush === 1'b1 && IF_ID_Write === 1'b0) begin
                errors++; $display("FAIL rand_flush_vs_hold[%0d]", n);
            end
            if (Mem_Busy)          m_state = 2'b11;
            else if (m_frozen)     m_state = 2'b00;
            else if (Branch_Taken) m_state = 2'b10;
            else if (lu)           m_state = 2'b01;
            else                   m_state = 2'b00;
            m_frozen = Mem_Busy;
            tick();
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_counters();
        reset = 1'b1;
        tick();
        checks++;
        if (Stall_Count !== 16'd0 || Flush_Count !== 16'd0) begin
            errors++; $display("FAIL cnt_reset stall %h flush %h exp 0 0", Stall_Count, Flush_Count);
        end
        reset = 1'b0;
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (Flush_Count !== 16'd3) begin errors++; $display("FAIL cnt_flush got %0d exp 3", Flush_Count); end
        set_in(5'd8, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (Stall_Count !== 16'd10) begin errors++; $display("FAIL cnt_stall10 got %0d exp 10", Stall_Count); end
        for (int i = 10; i < 70000; i++) tick();
        checks++;
        if (Stall_Count !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h exp ffff", Stall_Count); end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (Stall_Count !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold got %h exp ffff", Stall_Count); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (Stall_Count !== 16'd0 || Flush_Count !== 16'd0) begin
            errors++; $display("FAIL cnt_clear stall %h flush %h exp 0 0", Stall_Count, Flush_Count);
        end
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
    endtask
`endif

    initial begin
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        test_reset();
        test_load_use();
        test_rd_zero();
        test_priority();
        test_mem_wait();
        test_reset_async();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IF_ID_Rs1  in  5  rs1 of the instruction in decode.
- IF_ID_Rs2  in  5  rs2 of the instruction in decode.
- ID_EX_Rd  in  5  rd of the instruction in execute.
- ID_EX_MemRead  in  1  the instruction in execute is a load.
- Branch_Taken  in  1  branch or jump resolved taken in execute.
- Mem_Busy  in  1  data memory is not ready this cycle.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  zero the IF/ID register.
- ID_EX_Flush  out  1  insert a bubble into ID/EX by zeroing its controls.
- Pipe_Freeze  out  1  hold the ID/EX, EX/MEM and MEM/WB registers.
- State  out  2  current FSM state.
REQ-002 There is one clock domain; clk is the only clock, and reset is asynchronous and active-high.

Function
REQ-003 The FSM SHALL have four states: RUN=2'b00, LU_STALL=2'b01, FLUSH=2'b10, MEM_WAIT=2'b11. State SHALL show the registered state.
REQ-004 Outputs SHALL be combinational from the state and the current inputs (Mealy), so each event is handled in the cycle it is detected.
REQ-005 Default outputs: PC_Write=1, IF_ID_Write=1, all flush outputs=0, Pipe_Freeze=0.
REQ-006 In RUN, LU_STALL and FLUSH, events SHALL be evaluated with priority Mem_Busy > Branch_Taken > load-use.
REQ-007 Mem_Busy=1 SHALL drive PC_Write=0, IF_ID_Write=0 and Pipe_Freeze=1; the next state SHALL be MEM_WAIT.
REQ-008 Branch_Taken=1 (with Mem_Busy=0) SHALL drive IF_ID_Flush=1 and ID_EX_Flush=1 with PC_Write=1; the next state SHALL be FLUSH.
REQ-009 A load-use hazard SHALL be detected when ID_EX_MemRead=1, ID_EX_Rd!=0 and ID_EX_Rd equals IF_ID_Rs1 or IF_ID_Rs2.
REQ-010 A load-use hazard (with no higher-priority event) SHALL drive PC_Write=0, IF_ID_Write=0 and ID_EX_Flush=1; the next state SHALL be LU_STALL.
REQ-011 With no event, the next state SHALL be RUN.
REQ-012 LU_STALL and FLUSH SHALL last one cycle each and then re-evaluate events exactly as RUN does. A back-to-back load-use after LU_STALL SHALL stall again.
REQ-013 In MEM_WAIT, Pipe_Freeze=1, PC_Write=0 and IF_ID_Write=0 SHALL hold while Mem_Busy=1.
REQ-014 In MEM_WAIT, Branch_Taken and load-use SHALL be ignored, because execute is frozen and will reassert them.
REQ-015 In MEM_WAIT, the cycle Mem_Busy=0 SHALL drive default outputs, and the next state SHALL be RUN.
REQ-016 IF_ID_Flush and IF_ID_Write=0 SHALL never assert in the same cycle.

Reset
REQ-017 While reset=1: State=RUN, outputs at the REQ-005 defaults, and the counters of REQ-019 at 0, independent of clk.
REQ-018 Reset asserted mid-stall or mid-wait SHALL abort immediately. On reset release, the first edge SHALL evaluate events from RUN.

Configuration
REQ-019 With macro HAZARD_PERF_CNT_EN defined, the block SHALL add these outputs:
- Stall_Count[15:0]: increments every cycle with PC_Write=0.
- Flush_Count[15:0]: increments every cycle with IF_ID_Flush=1.
- Both counters saturate at 16'hFFFF and clear only on reset.
REQ-020 Without HAZARD_PERF_CNT_EN, these ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5 -> in the same cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle State=01 with default outputs.
REQ-022 Rd zero: ID_EX_MemRead=1, ID_EX_Rd=0, IF_ID_Rs1=0 -> no stall; State stays 00.
REQ-023 Priority: Branch_Taken=1 together with load-use (Rd=3, Rs1=3) -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; next State=10.
REQ-024 Memory wait: Mem_Busy=1 for 3 cycles with Branch_Taken=1 -> Pipe_Freeze=1 for 3 cycles, with no flush while frozen; State=11; after release State returns to 00.
REQ-025 Reset: assert reset during MEM_WAIT -> State=00 and PC_Write=1 asynchronously, before the next clk edge.
REQ-026 Counters (macro on): 70000 consecutive stall cycles -> Stall_Count=16'hFFFF, holds; reset -> 0.
